traffic_request_detector: RTL and testbench
===========================================

// Module: traffic_request_detector
// PURPOSE
//  Vehicle/pedestrian request front end for the 4-way traffic controller. It generates the
//  controller's request inputs and consumes the controller's light bus.
//  Raw buttons/loop sensors are synchronised, debounced and latched into per-direction requests.
//  Each request holds until that direction is served, i.e. until its green phase is decoded from
//  the light bus. Also reports per-direction wait-time starvation.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000      consecutive stable cycles needed to accept a sensor level change (>=2)
//  WAIT_W           16        width of per-direction wait counters
//  STARVE_LIMIT     16'd40000 wait count at/above which starve[i] asserts (< 2**WAIT_W)
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  synchronous active-low reset
//  sensor_in     in   4  raw async sensor/button per direction, active high, bit i = direction i
//  lights_in     in   8  controller light bus: [1]R0 [2]G0 [3]R1 [4]G1 [5]R2 [6]G2 [7]R3, [0] ignored
//  req_out       out  4  latched requests, driven to the controller request input bits [3:0]
//  served_pulse  out  4  1-cycle pulse when direction i is decoded as served
//  starve        out  4  req_out[i] pending with wait_cnt[i] >= STARVE_LIMIT
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low (clk, rst_n).
//  Reset: on a clk edge with rst_n=0, every register clears. req_out, served_pulse and starve
//   are 0. Sync flops, debounced levels, debounce counters, wait counters and light history are 0.
//   Reset mid-operation discards all pending requests.
//  Sync: 2-flop synchroniser per sensor_in bit. sync[i] = sensor_in[i] delayed 2 cycles.
//  Debounce (per i): deb[i] is the accepted level. db_cnt[i] clears whenever sync[i]==deb[i].
//   Otherwise db_cnt[i] increments. When sync[i]!=deb[i] and db_cnt[i]==DEBOUNCE_CYCLES-1,
//   deb[i] takes the value of sync[i] and db_cnt[i] clears. Any glitch shorter than
//   DEBOUNCE_CYCLES restarts the count.
//   Latency: sensor_in rises before edge t and stays high -> deb rises at edge t+2+DEBOUNCE_CYCLES.
//  Press: press[i] = deb[i] & ~deb_d[i], where deb_d[i] is deb[i] delayed one cycle.
//   Only rising edges count; a held sensor does not re-request.
//  Light decode: lq <= lights_in and lq2 <= lq, both registered.
//   served[i] for i=0..2: green bit rises (lq[G]=1, lq2[G]=0).
//   served[3]: R3 falls (lq2[7]=1, lq[7]=0). Direction 3 has no green bit on the bus; the fall of
//   R3 marks its RED->GREEN transition.
//   served_pulse <= served, so a lights_in change before edge t is visible at edge t+2.
//  Request latch (per i), evaluated on the same edge:
//   served[i] -> req_out[i] <= 0. Clear wins over a simultaneous press, because a vehicle
//   arriving during green proceeds.
//   else press[i] -> req_out[i] <= 1.
//   else hold.
//   A press while already pending is a no-op.
//  Wait counter (per i): if req_out[i]==0 or served[i], wait_cnt <= 0.
//   Otherwise wait_cnt <= wait_cnt+1, saturating at 2**WAIT_W-1; it never wraps.
//  Starve: starve[i] <= req_out[i] & (wait_cnt[i] >= STARVE_LIMIT), registered.
//   It drops on the cycle after the request clears.
//  Simultaneous events: directions are fully independent. Multiple served pulses in one
//   cycle are legal and each is handled on its own.
//  lights_in is treated as synchronous to clk (same domain as the controller); it is not
//   synchronised beyond the lq/lq2 stages.
// TESTING  (bench: DEBOUNCE_CYCLES=4, STARVE_LIMIT=20, WAIT_W=8)
//  1 Reset: rst_n=0 for 2 cycles with sensor_in=4'hF and lights_in=8'hFF
//     -> req_out, served_pulse and starve are all 0 while reset is held.
//  2 Debounce latency: sensor_in[1] 0->1 before edge 10 and held
//     -> deb rises at edge 16; req_out[1]=1 from edge 17.
//     A 3-cycle pulse on sensor_in[1] -> req_out stays 0.
//  3 Service: req_out[0]=1, then lights_in 8'h02->8'h04 before edge 40
//     -> served_pulse=4'b0001 at edge 42 only; req_out[0]=0 at edge 42.
//  4 Direction 3: req_out[3]=1, then lights_in 8'h80->8'h00
//     -> served_pulse[3] for 1 cycle and req_out[3] cleared.
//     A 8'h00->8'h80 transition -> no pulse.
//  5 Simultaneous: press[2] on the same edge as served[2]
//     -> req_out[2] stays 0.
//     Press on 0 and 1 together -> both req bits set on the same edge.
//  6 Starvation/saturation: hold req_out[2] pending, no green
//     -> starve[2]=1 one cycle after wait_cnt reaches 20; wait_cnt saturates at 255.
//     Then a G2 rising edge -> wait_cnt=0 and starve[2]=0 on the next edge.
//     Reset asserted mid-wait -> everything clears on the next edge.

Source files
------------

// File: rtl/traffic_request_detector.sv
// Request front end for the 4-way traffic controller.
// Synchronises and debounces raw sensors and latches a request per direction.
// Each request clears when the light bus shows that direction turning green.
// Each direction also reports wait-time starvation while its request is pending.
module traffic_request_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned WAIT_W          = 16,
  parameter int unsigned STARVE_LIMIT    = 40000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sensor_in,
  input  logic [7:0] lights_in,
  output logic [3:0] req_out,
  output logic [3:0] served_pulse,
  output logic [3:0] starve
);

  localparam int unsigned       DB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  logic [3:0]             sync1_q, sync1_d;
  logic [3:0]             sync2_q, sync2_d;
  logic [3:0]             deb_q, deb_d;
  logic [3:0]             deb_dly_q, deb_dly_d;
  logic [3:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [7:0]             lq_q, lq_d;
  logic [7:0]             lq2_q, lq2_d;
  logic [3:0]             req_q, req_d;
  logic [3:0]             served_pulse_q, served_pulse_d;
  logic [3:0]             starve_q, starve_d;
  logic [3:0][WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [3:0] press;
  logic [3:0] served;
  logic       lights_unused;

  // Red bits of directions 0..2 and bit 0 carry no service information.
  assign lights_unused = ^{lq_q[5], lq_q[3], lq_q[1:0], lq2_q[5], lq2_q[3], lq2_q[1:0]};

  // Edge detection on debounced sensors and on the registered light bus.
  always_comb begin
    press     = deb_q & ~deb_dly_q;
    served    = '0;
    served[0] = lq_q[2] & ~lq2_q[2];
    served[1] = lq_q[4] & ~lq2_q[4];
    served[2] = lq_q[6] & ~lq2_q[6];
    // Direction 3 has no green bit: its RED->GREEN change shows as R3 falling.
    served[3] = lq2_q[7] & ~lq_q[7];
  end

  // Next-state logic: synchroniser, debouncer, request latch, wait/starve tracking.
  always_comb begin
    sync1_d        = sensor_in;
    sync2_d        = sync1_q;
    deb_d          = deb_q;
    deb_dly_d      = deb_q;
    db_cnt_d       = db_cnt_q;
    lq_d           = lights_in;
    lq2_d          = lq_q;
    req_d          = req_q;
    served_pulse_d = served;
    starve_d       = '0;
    wait_cnt_d     = wait_cnt_q;
    for (int i = 0; i < 4; i++) begin
      // Accept a new level only after it has been seen DEBOUNCE_CYCLES times in a row.
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end

      // Service beats a simultaneous press: a vehicle arriving on green proceeds.
      if (served[i]) begin
        req_d[i] = 1'b0;
      end else if (press[i]) begin
        req_d[i] = 1'b1;
      end

      if (!req_q[i] || served[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != WAIT_MAX) begin
        wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
      end

      starve_d[i] = req_q[i] & (wait_cnt_q[i] >= STARVE_TH);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      deb_dly_q      <= '0;
      db_cnt_q       <= '0;
      lq_q           <= '0;
      lq2_q          <= '0;
      req_q          <= '0;
      served_pulse_q <= '0;
      starve_q       <= '0;
      wait_cnt_q     <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      deb_dly_q      <= deb_dly_d;
      db_cnt_q       <= db_cnt_d;
      lq_q           <= lq_d;
      lq2_q          <= lq2_d;
      req_q          <= req_d;
      served_pulse_q <= served_pulse_d;
      starve_q       <= starve_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign req_out      = req_q;
  assign served_pulse = served_pulse_q;
  assign starve       = starve_q;

endmodule

// File: tb/tb_traffic_request_detector.sv
// Directed bench for traffic_request_detector (DEBOUNCE_CYCLES=4, STARVE_LIMIT=20, WAIT_W=8).
// Inputs change 1 time unit after an edge and are first sampled on the following edge.
module tb_traffic_request_detector;

  logic       clk;
  logic       rst_n;
  logic [3:0] sensor_in;
  logic [7:0] lights_in;
  logic [3:0] req_out;
  logic [3:0] served_pulse;
  logic [3:0] starve;

  int checks;
  int errors;

  traffic_request_detector #(
    .DEBOUNCE_CYCLES(4),
    .WAIT_W         (8),
    .STARVE_LIMIT   (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor_in   (sensor_in),
    .lights_in   (lights_in),
    .req_out     (req_out),
    .served_pulse(served_pulse),
    .starve      (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    sensor_in = 4'hF;
    lights_in = 8'hFF;

    // Reset held with all inputs active
    tick(1);
    check("rst1_req", 32'(req_out), 32'h0);
    check("rst1_served", 32'(served_pulse), 32'h0);
    check("rst1_starve", 32'(starve), 32'h0);
    tick(1);
    check("rst2_req", 32'(req_out), 32'h0);
    check("rst2_served", 32'(served_pulse), 32'h0);
    check("rst2_starve", 32'(starve), 32'h0);
    sensor_in = 4'h0;
    lights_in = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Glitch of 3 cycles on sensor 1 must be rejected
    sensor_in = 4'b0010;
    tick(3);
    sensor_in = 4'b0000;
    tick(10);
    check("glitch_req", 32'(req_out), 32'h0);

    // Debounce latency: change after edge t, deb at t+6, request at t+7
    sensor_in = 4'b0010;
    tick(6);
    check("lat_req_early", 32'(req_out), 32'h0);
    tick(1);
    check("lat_req_set", 32'(req_out), 32'b0010);
    sensor_in = 4'b0000;
    tick(8);
    check("lat_req_hold", 32'(req_out), 32'b0010);

    // Service of direction 0 via G0 rising
    lights_in = 8'h02;
    sensor_in = 4'b0001;
    tick(7);
    check("svc0_req_set", 32'(req_out), 32'b0011);
    sensor_in = 4'b0000;
    tick(8);
    lights_in = 8'h04;
    tick(1);
    check("svc0_no_pulse_yet", 32'(served_pulse), 32'h0);
    check("svc0_req_pending", 32'(req_out), 32'b0011);
    tick(1);
    check("svc0_pulse", 32'(served_pulse), 32'b0001);
    check("svc0_req_clr", 32'(req_out), 32'b0010);
    tick(1);
    check("svc0_pulse_end", 32'(served_pulse), 32'h0);

    // Service of direction 1 via G1 rising (G0 falling is not service)
    lights_in = 8'h08;
    tick(2);
    check("svc1_g0_fall", 32'(served_pulse), 32'h0);
    lights_in = 8'h10;
    tick(2);
    check("svc1_pulse", 32'(served_pulse), 32'b0010);
    check("svc1_req_clr", 32'(req_out), 32'b0000);

    // Direction 3: R3 falling serves, R3 rising does not
    lights_in = 8'h80;
    sensor_in = 4'b1000;
    tick(7);
    check("d3_req_set", 32'(req_out), 32'b1000);
    sensor_in = 4'b0000;
    tick(8);
    lights_in = 8'h00;
    tick(1);
    check("d3_no_pulse_yet", 32'(served_pulse), 32'h0);
    tick(1);
    check("d3_pulse", 32'(served_pulse), 32'b1000);
    check("d3_req_clr", 32'(req_out), 32'b0000);
    tick(1);
    check("d3_pulse_end", 32'(served_pulse), 32'h0);
    lights_in = 8'h80;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("d3_rise_no_pulse", 32'(served_pulse), 32'h0);
    end

    // Press on direction 2 coincides with G2 rising: clear wins
    sensor_in = 4'b0100;
    tick(5);
    lights_in = 8'hC0;
    tick(2);
    check("sim_served2", 32'(served_pulse), 32'b0100);
    check("sim_req2_clear", 32'(req_out), 32'b0000);
    tick(1);
    check("sim_req2_stays", 32'(req_out), 32'b0000);
    sensor_in = 4'b0000;
    tick(8);

    // Presses on 0 and 1 together set both on the same edge
    sensor_in = 4'b0011;
    tick(6);
    check("dual_req_early", 32'(req_out), 32'b0000);
    tick(1);
    check("dual_req_set", 32'(req_out), 32'b0011);
    sensor_in = 4'b0000;
    tick(8);

    // Starvation and saturation on direction 2
    lights_in = 8'h80;
    sensor_in = 4'b0100;
    tick(7);
    check("stv_req_set", 32'(req_out[2]), 32'h1);
    sensor_in = 4'b0000;
    tick(20);
    check("stv_wait20", 32'(dut.wait_cnt_q[2]), 32'd20);
    check("stv_not_yet", 32'(starve[2]), 32'h0);
    tick(1);
    check("stv_asserted", 32'(starve[2]), 32'h1);
    tick(240);
    check("stv_sat", 32'(dut.wait_cnt_q[2]), 32'd255);
    check("stv_still", 32'(starve[2]), 32'h1);
    lights_in = 8'hC0;
    tick(2);
    check("stv_served", 32'(served_pulse), 32'b0100);
    check("stv_req_clr", 32'(req_out[2]), 32'h0);
    check("stv_wait_clr", 32'(dut.wait_cnt_q[2]), 32'd0);
    tick(1);
    check("stv_starve_clr", 32'(starve[2]), 32'h0);

    // Reset mid-wait clears everything on the next edge
    sensor_in = 4'b0100;
    tick(7);
    sensor_in = 4'b0000;
    tick(10);
    check("mid_pre_req", 32'(req_out), 32'b0111);
    check("mid_pre_starve", 32'(starve), 32'b0011);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_req", 32'(req_out), 32'h0);
    check("mid_rst_starve", 32'(starve), 32'h0);
    check("mid_rst_served", 32'(served_pulse), 32'h0);
    check("mid_rst_wait", 32'(dut.wait_cnt_q[2]), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
